// File: rtl/mem_dp.sv
// Dual-port storage array: synchronous write, combinational read.
// Contents are never reset.
module mem_dp #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          wr,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers,
// level flags and sticky overflow/underflow errors.
module fifo_sync #(
  parameter int DW     = 16,
  parameter int AW     = 4,
  parameter int AF_LVL = (2**AW) - 2,
  parameter int AE_LVL = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  input  logic          err_clr
);

  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF = PW'(AF_LVL);
  localparam logic [PW-1:0] AE = PW'(AE_LVL);

  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          push_ok;
  logic          pop_ok;
  logic          ovf_set;
  logic          udf_set;

  // Flags depend on registered pointers only.
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign count = wp - rp;

  assign almost_full  = (count >= AF);
  assign almost_empty = (count <= AE);

  // A pop on a full FIFO frees the slot the push lands in.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign ovf_set = push && full && !pop;
  assign udf_set = pop && empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (err_clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set) overflow  <= 1'b1;
      if (udf_set) underflow <= 1'b1;
    end
  end

  mem_dp #(
    .DW(DW),
    .AW(AW)
  ) u_mem (
    .clk  (clk),
    .wr   (push_ok),
    .waddr(wp[AW-1:0]),
    .wdata(din),
    .raddr(rp[AW-1:0]),
    .rdata(dout)
  );

endmodule
